// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
// Sequenced ALU control unit for the multicycle core. Decodes opcode,
// function field and the force-ADD signal into a 3-bit ALU control code,
// then evaluates the operation on operands latched at acceptance.
// Single-cycle ops complete one cycle after acceptance. Iterative multiply
// (shift-add) and variable shifts (one bit per cycle) run behind a
// start/busy/done handshake.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   : MUL decode, MUL state and the result_hi datapath are built
//   undefined : func_field=1000 decodes as illegal, o_result_hi tied to 0
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_start                 request, sampled only while not busy
//   i_op, i_func_field      opcode and R-type function field
//   i_csig                  force ADD (PC increment / address generation)
//   i_a, i_b                operand A, operand B / shift amount
//   o_alu_ctrl              control code of the last accepted operation
//   o_busy                  iterative operation in progress
//   o_done                  one-cycle pulse, result valid
//   o_result, o_result_hi   result (low half for MUL), MUL high half
//   o_zero                  o_result == 0
//   o_err                   last accepted operation was illegal
module alu_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int OP_W   = 4,
  parameter int FUNC_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [OP_W-1:0]   i_op,
  input  logic [FUNC_W-1:0] i_func_field,
  input  logic              i_csig,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  output logic [2:0]        o_alu_ctrl,
  output logic              o_busy,
  output logic              o_done,
  output logic [WIDTH-1:0]  o_result,
  output logic [WIDTH-1:0]  o_result_hi,
  output logic              o_zero,
  output logic              o_err
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;

  localparam logic [2:0] C_AND = 3'b000;
  localparam logic [2:0] C_OR  = 3'b001;
  localparam logic [2:0] C_XOR = 3'b010;
  localparam logic [2:0] C_ADD = 3'b011;
  localparam logic [2:0] C_SUB = 3'b100;
  localparam logic [2:0] C_SLT = 3'b101;
  localparam logic [2:0] C_SLL = 3'b110;
  localparam logic [2:0] C_SRL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SHIFT} state_t;

  state_t             r_state;
  logic [2:0]         r_aluCtrl;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_shVal;
  logic               r_shLeft;

  logic [2:0]         w_code;
  logic               w_illegal;
  logic               w_isVar;
  logic [SH_W-1:0]    w_amt;
  logic [WIDTH-1:0]   w_single;
  logic [WIDTH-1:0]   w_shNext;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   r_resultHi;
  logic [WIDTH-1:0]   r_mcand;
  // Upper half accumulates partial products, lower half holds the
  // not-yet-consumed multiplier bits; both shift right together.
  logic [2*WIDTH-1:0] r_prod;
  logic               w_isMul;
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_mulNext;
`endif

  function automatic logic [WIDTH-1:0] aluOp(input logic [2:0] code,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [SH_W-1:0] sh;
    sh    = b[SH_W-1:0];
    aluOp = '0;
    case (code)
      C_AND: aluOp = a & b;
      C_OR:  aluOp = a | b;
      C_XOR: aluOp = a ^ b;
      C_ADD: aluOp = a + b;
      C_SUB: aluOp = a - b;
      C_SLT: aluOp = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      C_SLL: aluOp = a << sh;
      C_SRL: aluOp = a >> sh;
      default: aluOp = '0;
    endcase
  endfunction

  // csig overrides everything; illegal ops keep the ADD code.
  always_comb begin
    w_code    = C_ADD;
    w_illegal = 1'b0;
    w_isVar   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_isMul   = 1'b0;
`endif
    if (i_csig) begin
      w_code = C_ADD;
    end else if (i_op == '0) begin
      if (!i_func_field[3]) begin
        w_code = i_func_field[2:0];
      end else if (i_func_field == FUNC_W'(8)) begin
`ifdef ALU_SEQ_MUL_EN
        w_isMul = 1'b1;
`else
        w_illegal = 1'b1;
`endif
      end else if (i_func_field == FUNC_W'(9)) begin
        w_code  = C_SLL;
        w_isVar = 1'b1;
      end else if (i_func_field == FUNC_W'(10)) begin
        w_code  = C_SRL;
        w_isVar = 1'b1;
      end else begin
        w_illegal = 1'b1;
      end
    end else if (i_op < OP_W'(8)) begin
      w_code = i_op[2:0];
    end else if (i_op == OP_W'(12) || i_op == OP_W'(13)) begin
      w_code = C_SUB;
    end else begin
      w_code = C_ADD;
    end
  end

  assign w_amt    = i_b[SH_W-1:0];
  // A zero-amount variable shift falls through here and yields i_a.
  assign w_single = aluOp(w_code, i_a, i_b);
  assign w_shNext = r_shLeft ? {r_shVal[WIDTH-2:0], 1'b0}
                             : {1'b0, r_shVal[WIDTH-1:1]};

`ifdef ALU_SEQ_MUL_EN
  assign w_mulSum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_prod[0] ? r_mcand : {WIDTH{1'b0}})};
  assign w_mulNext = {w_mulSum, r_prod[WIDTH-1:1]};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_aluCtrl <= C_ADD;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_shVal   <= '0;
      r_shLeft  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_resultHi <= '0;
      r_mcand    <= '0;
      r_prod     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_aluCtrl <= w_code;
            if (w_illegal) begin
              r_result <= '0;
              r_zero   <= 1'b1;
              r_err    <= 1'b1;
              r_done   <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
              r_resultHi <= '0;
            end else if (w_isMul) begin
              r_mcand <= i_a;
              r_prod  <= {{WIDTH{1'b0}}, i_b};
              r_cnt   <= CNT_W'(WIDTH);
              r_busy  <= 1'b1;
              r_state <= S_MUL;
`endif
            end else if (w_isVar && (w_amt != '0)) begin
              r_shVal  <= i_a;
              r_shLeft <= (w_code == C_SLL);
              r_cnt    <= {1'b0, w_amt};
              r_busy   <= 1'b1;
              r_state  <= S_SHIFT;
            end else begin
              r_result <= w_single;
              r_zero   <= (w_single == '0);
              r_err    <= 1'b0;
              r_done   <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
              r_resultHi <= '0;
`endif
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          r_prod <= w_mulNext;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_result   <= w_mulNext[WIDTH-1:0];
            r_resultHi <= w_mulNext[2*WIDTH-1:WIDTH];
            r_zero     <= (w_mulNext[WIDTH-1:0] == '0);
            r_err      <= 1'b0;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
`endif
        S_SHIFT: begin
          r_shVal <= w_shNext;
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_result <= w_shNext;
            r_zero   <= (w_shNext == '0);
            r_err    <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
`ifdef ALU_SEQ_MUL_EN
            r_resultHi <= '0;
`endif
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_alu_ctrl = r_aluCtrl;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_result   = r_result;
  assign o_zero     = r_zero;
  assign o_err      = r_err;
`ifdef ALU_SEQ_MUL_EN
  assign o_result_hi = r_resultHi;
`else
  assign o_result_hi = '0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl: directed vectors with hand-computed results.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [3:0]  op;
  logic [3:0]  funcField;
  logic        csig;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  aluCtrl;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] resultHi;
  logic        zero;
  logic        err;

  int nChecks = 0;
  int nFails  = 0;
  int cycles;
  bit overlap;
  bit sawDone;

  alu_seq_ctrl #(.WIDTH(16), .OP_W(4), .FUNC_W(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_start      (start),
    .i_op         (op),
    .i_func_field (funcField),
    .i_csig       (csig),
    .i_a          (a),
    .i_b          (b),
    .o_alu_ctrl   (aluCtrl),
    .o_busy       (busy),
    .o_done       (done),
    .o_result     (result),
    .o_result_hi  (resultHi),
    .o_zero       (zero),
    .o_err        (err)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports a failure with tag and values
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge: holds start for exactly one rising edge and
  // returns at the following falling edge, where latency-1 results are visible
  task automatic applyStimulus(input logic [3:0] opV, input logic [3:0] funcV,
                               input logic csigV, input logic [15:0] aV,
                               input logic [15:0] bV);
    start     = 1'b1;
    op        = opV;
    funcField = funcV;
    csig      = csigV;
    a         = aV;
    b         = bV;
    @(negedge clk);
    start = 1'b0;
    csig  = 1'b0;
  endtask

  // Counts falling edges until done, bounded; also flags busy&done overlap
  task automatic waitDone(output int n, output bit ov);
    n  = 0;
    ov = 1'b0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1 && done === 1'b1) ov = 1'b1;
    end
  endtask

  // Directed sequence
  initial begin
    rstN = 1'b0; start = 1'b0; op = '0; funcField = '0; csig = 1'b0;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_alu_ctrl", 32'(aluCtrl), 32'h3);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_result", 32'(result), 32'h0);
    checkOutput("rst_result_hi", 32'(resultHi), 32'h0);
    checkOutput("rst_zero", 32'(zero), 32'h1);
    checkOutput("rst_err", 32'(err), 32'h0);
    rstN = 1'b1;
    @(negedge clk);

    // csig forces ADD regardless of op
    applyStimulus(4'd5, 4'h0, 1'b1, 16'd3, 16'd4);
    checkOutput("csig_alu_ctrl", 32'(aluCtrl), 32'h3);
    checkOutput("csig_result", 32'(result), 32'h7);
    checkOutput("csig_done", 32'(done), 32'h1);
    checkOutput("csig_busy", 32'(busy), 32'h0);
    @(negedge clk);
    checkOutput("done_pulse_drops", 32'(done), 32'h0);
    checkOutput("result_holds", 32'(result), 32'h7);

    // R-type single-cycle ops
    applyStimulus(4'd0, 4'b0100, 1'b0, 16'd5, 16'd5);
    checkOutput("sub_result", 32'(result), 32'h0);
    checkOutput("sub_zero", 32'(zero), 32'h1);
    checkOutput("sub_alu_ctrl", 32'(aluCtrl), 32'h4);
    applyStimulus(4'd0, 4'b0101, 1'b0, 16'hFFFF, 16'h0001);
    checkOutput("slt_result", 32'(result), 32'h1);
    checkOutput("slt_zero", 32'(zero), 32'h0);
    applyStimulus(4'd0, 4'b0000, 1'b0, 16'hF0F0, 16'hFF00);
    checkOutput("and_result", 32'(result), 32'hF000);
    applyStimulus(4'd0, 4'b0001, 1'b0, 16'hF0F0, 16'hFF00);
    checkOutput("or_result", 32'(result), 32'hFFF0);
    applyStimulus(4'd0, 4'b0010, 1'b0, 16'hF0F0, 16'hFF00);
    checkOutput("xor_result", 32'(result), 32'h0FF0);
    applyStimulus(4'd0, 4'b0110, 1'b0, 16'h0001, 16'h0014);
    checkOutput("sll_upper_amt_ignored", 32'(result), 32'h0010);
    applyStimulus(4'd0, 4'b0111, 1'b0, 16'h8000, 16'h0003);
    checkOutput("srl_result", 32'(result), 32'h1000);

    // I-type decode
    applyStimulus(4'd2, 4'hF, 1'b0, 16'd5, 16'd3);
    checkOutput("itype_xor_result", 32'(result), 32'h6);
    checkOutput("itype_xor_ctrl", 32'(aluCtrl), 32'h2);
    applyStimulus(4'd12, 4'hF, 1'b0, 16'd3, 16'd5);
    checkOutput("itype_sub_result", 32'(result), 32'hFFFE);
    checkOutput("itype_sub_ctrl", 32'(aluCtrl), 32'h4);
    applyStimulus(4'd9, 4'h0, 1'b0, 16'hFFFF, 16'd2);
    checkOutput("itype_add_wrap", 32'(result), 32'h1);
    checkOutput("itype_add_ctrl", 32'(aluCtrl), 32'h3);

    // MUL
    applyStimulus(4'd0, 4'b1000, 1'b0, 16'h1234, 16'h0100);
`ifdef ALU_SEQ_MUL_EN
    checkOutput("mul_busy", 32'(busy), 32'h1);
    waitDone(cycles, overlap);
    checkOutput("mul_latency", 32'(cycles), 32'd16);
    checkOutput("mul_overlap", 32'(overlap), 32'h0);
    checkOutput("mul_result", 32'(result), 32'h3400);
    checkOutput("mul_result_hi", 32'(resultHi), 32'h0012);
    checkOutput("mul_alu_ctrl", 32'(aluCtrl), 32'h3);
    checkOutput("mul_err", 32'(err), 32'h0);
`else
    checkOutput("mul_off_done", 32'(done), 32'h1);
    checkOutput("mul_off_err", 32'(err), 32'h1);
    checkOutput("mul_off_result", 32'(result), 32'h0);
    checkOutput("mul_off_busy", 32'(busy), 32'h0);
`endif

    // SRLV by 15 with an ignored start and operand change while busy
    applyStimulus(4'd0, 4'b1010, 1'b0, 16'h8000, 16'd15);
    checkOutput("srlv_busy", 32'(busy), 32'h1);
    start = 1'b1; csig = 1'b1; a = 16'h0000; b = 16'h0000;
    @(negedge clk);
    start = 1'b0; csig = 1'b0;
    checkOutput("srlv_busy_after_poke", 32'(busy), 32'h1);
    waitDone(cycles, overlap);
    checkOutput("srlv_latency", 32'(cycles + 1), 32'd15);
    checkOutput("srlv_overlap", 32'(overlap), 32'h0);
    checkOutput("srlv_result", 32'(result), 32'h1);
    checkOutput("srlv_result_hi", 32'(resultHi), 32'h0);
    checkOutput("srlv_alu_ctrl", 32'(aluCtrl), 32'h7);
    @(negedge clk);
    checkOutput("srlv_no_second_done", 32'(done), 32'h0);

    // Zero-amount variable shift completes in one cycle
    applyStimulus(4'd0, 4'b1010, 1'b0, 16'h8000, 16'd0);
    checkOutput("srlv0_done", 32'(done), 32'h1);
    checkOutput("srlv0_result", 32'(result), 32'h8000);
    checkOutput("srlv0_alu_ctrl", 32'(aluCtrl), 32'h7);

    // SLLV, upper amount bits ignored (0x24 -> 4)
    applyStimulus(4'd0, 4'b1001, 1'b0, 16'h0003, 16'h0024);
    waitDone(cycles, overlap);
    checkOutput("sllv_latency", 32'(cycles), 32'd4);
    checkOutput("sllv_result", 32'(result), 32'h0030);
    checkOutput("sllv_alu_ctrl", 32'(aluCtrl), 32'h6);

    // Reset in the middle of an iterative operation
`ifdef ALU_SEQ_MUL_EN
    applyStimulus(4'd0, 4'b1000, 1'b0, 16'h1234, 16'h0100);
`else
    applyStimulus(4'd0, 4'b1001, 1'b0, 16'h0001, 16'd15);
`endif
    repeat (4) @(negedge clk);
    checkOutput("abort_busy_before", 32'(busy), 32'h1);
    rstN = 1'b0;
    #1;
    checkOutput("abort_alu_ctrl", 32'(aluCtrl), 32'h3);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_result", 32'(result), 32'h0);
    checkOutput("abort_result_hi", 32'(resultHi), 32'h0);
    checkOutput("abort_zero", 32'(zero), 32'h1);
    checkOutput("abort_err", 32'(err), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'h0);

    // Illegal function, then ADD accepted in the done cycle
    applyStimulus(4'd0, 4'b1111, 1'b0, 16'h1234, 16'h5678);
    checkOutput("illegal_done", 32'(done), 32'h1);
    checkOutput("illegal_err", 32'(err), 32'h1);
    checkOutput("illegal_result", 32'(result), 32'h0);
    checkOutput("illegal_zero", 32'(zero), 32'h1);
    applyStimulus(4'd0, 4'b0011, 1'b0, 16'h7FFF, 16'h0001);
    checkOutput("add_after_illegal_done", 32'(done), 32'h1);
    checkOutput("add_after_illegal_result", 32'(result), 32'h8000);
    checkOutput("add_after_illegal_err", 32'(err), 32'h0);
    checkOutput("add_after_illegal_zero", 32'(zero), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Parametrised, sequenced ALU control unit for the multicycle RISC core. It decodes `op`, `func_field` and `csig` into a 3-bit ALU control code and evaluates the operation on registered operands. Single-cycle operations finish in one cycle. Iterative multiply and variable-amount shifts run over several cycles behind a start/busy/done handshake. It sits between the main control FSM and the register file/ALU result latch, and replaces the purely combinational ALU-control decode.

## Interface
- `WIDTH`, 16: operand/result width (≥4, power of two)
- `OP_W`, 4: opcode width
- `FUNC_W`, 4: function-field width
- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: request; sampled only when `busy`=0
- `op` in OP_W: opcode
- `func_field` in FUNC_W: R-type function field
- `csig` in 1: force ADD (PC increment / address generation)
- `a` in WIDTH: operand A
- `b` in WIDTH: operand B / shift amount
- `alu_ctrl` out 3: decoded control code of the accepted operation
- `busy` out 1: iterative operation in progress
- `done` out 1: one-cycle pulse, `result` valid
- `result` out WIDTH: result (low half for MUL)
- `result_hi` out WIDTH: MUL high half; 0 for all other operations
- `zero` out 1: `result`==0, registered with `result`
- `err` out 1: the last accepted operation was illegal

## Operation
- Control codes: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SLT (signed), 110 SLL, 111 SRL.
- Decode priority: `csig`=1 gives ADD for any `op`/`func`.
- R-type (`op`=0):
  - `func_field[3]`=0: code = `func_field[2:0]`; single-cycle. SLL/SRL shift by `b[log2(WIDTH)-1:0]`.
  - `func_field`=1000: MUL, iterative.
  - 1001: SLLV, iterative.
  - 1010: SRLV, iterative.
  - Other 1xxx: illegal.
- I-type:
  - `op`=1..7: code = `op[2:0]`; single-cycle.
  - `op`=8..11 and 14..15: ADD.
  - `op`=12..13: SUB (branch compare).
- States and transitions:
  - IDLE: `start` with a single-cycle or illegal op → result registered, `done` pulse, stay in IDLE.
  - IDLE: `start` with MUL → MUL. With SLLV/SRLV and amount>0 → SHIFT. With amount=0 → complete as single-cycle with `result`=`a`.
  - MUL: shift-add on latched `a`,`b`, one bit per cycle, WIDTH iterations, unsigned 2·WIDTH product → IDLE with `done`.
  - SHIFT: one bit position per cycle; counter loaded with the amount, decremented to 0 → IDLE with `done`.
- Illegal op: `result`=0, `result_hi`=0, `err`=1, `zero`=1, `done` pulse. A legal completion clears `err`.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. SLT gives 1 or 0, zero-extended. Shift amount bits above log2(WIDTH) are ignored.
- `alu_ctrl` is held from acceptance until the next accepted `start`. MUL reports 011 and SLLV/SRLV report 110/111. `csig` is sampled only at acceptance.
- `start` while `busy`=1 is ignored; operands are latched at acceptance.
- `start` in the same cycle `done` is high is accepted, because the state is IDLE.
- `result`, `result_hi`, `zero` and `err` hold their values between completions.

## Timing
- Accept at edge N:
  - Single-cycle, illegal, or zero-amount shift: `done`=1 and `result` valid after edge N (latency 1).
  - MUL: `busy`=1 for WIDTH cycles, `done` after edge N+WIDTH (16 cycles at default).
  - SLLV/SRLV with amount k>0: `busy`=1 for k cycles, `done` after edge N+k.
- `done` and `busy` are never high together.
- Reset values: `alu_ctrl`=011, `busy`=0, `done`=0, `result`=0, `result_hi`=0, `zero`=1, `err`=0, state IDLE.
- `rst_n` low mid-operation aborts immediately with the values above and produces no `done` pulse.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL decode, the MUL state and the `result_hi` datapath are compiled in.
- Undefined: `func_field`=1000 decodes as illegal (`err`=1, latency 1); `result_hi` is tied to 0 and no multiplier logic is present.

## Test plan
- `csig`=1, `op`=5, `a`=3, `b`=4, `start` → next cycle `alu_ctrl`=011, `result`=7, `done`=1.
- R-type SUB, `a`=5, `b`=5 → `result`=0, `zero`=1. SLT with `a`=16'hFFFF, `b`=1 → `result`=1.
- MUL, `a`=16'h1234, `b`=16'h0100 (`ALU_SEQ_MUL_EN`) → `busy` 16 cycles, then `result`=16'h3400, `result_hi`=16'h0012. Without the macro → `err`=1 after 1 cycle.
- SRLV, `a`=16'h8000:
  - `b`=15 → `done` after 15 cycles, `result`=1.
  - `b`=0 → 1 cycle, `result`=16'h8000.
  - `start` asserted while busy → ignored.
- `rst_n` pulsed low at cycle 5 of a MUL → all outputs return to reset values; no `done` pulse.
- `func_field`=1111 → `err`=1, `result`=0. A following ADD started in the `done` cycle completes and clears `err`.
